nearest_centroid_sel: RTL and testbench



---
 rtl/nearest_centroid_sel_pkg.sv | 13 +
 rtl/nearest_centroid_sel_min_cmp_reg.sv | 36 +++
 rtl/nearest_centroid_sel.sv | 102 ++++++++++
 tb/tb_nearest_centroid_sel.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nearest_centroid_sel_pkg.sv
// Shared k-means definitions: default widths and the assignment FSM encoding.
package nearest_centroid_sel_pkg;

    localparam int unsigned DW_DEF = 64;
    localparam int unsigned K_DEF  = 4;
    localparam int unsigned CW_DEF = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/nearest_centroid_sel_min_cmp_reg.sv
// Running-minimum register: the first beat loads unconditionally, later beats
// load only when strictly smaller, so ties keep the lower index.
module min_cmp_reg #(
    parameter int unsigned DW = 64,
    parameter int unsigned IW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_en,
    input  logic          i_first,
    input  logic [DW-1:0] i_dist,
    input  logic [IW-1:0] i_idx,
    output logic [DW-1:0] o_best_dist,
    output logic [IW-1:0] o_best_idx
);

    logic [DW-1:0] r_best_dist;
    logic [IW-1:0] r_best_idx;
    logic          w_load;

    assign w_load = i_en && (i_first || (i_dist < r_best_dist));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_dist <= '0;
            r_best_idx  <= '0;
        end else if (w_load) begin
            r_best_dist <= i_dist;
            r_best_idx  <= i_idx;
        end
    end

    assign o_best_dist = r_best_dist;
    assign o_best_idx  = r_best_idx;

endmodule

// File: rtl/nearest_centroid_sel.sv
// Nearest-centroid selector: reduces K distances per point to (index, distance)
// and hands the result downstream on a valid/ready handshake.
module nearest_centroid_sel
    import nearest_centroid_sel_pkg::*;
#(
    parameter  int unsigned DW = DW_DEF,
    parameter  int unsigned K  = K_DEF,
    parameter  int unsigned CW = CW_DEF,
    localparam int unsigned IW = $clog2(K)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [DW-1:0] dist_in,
    input  logic          dist_valid,
    output logic          dist_ready,
    output logic [IW-1:0] best_idx,
    output logic [DW-1:0] best_dist,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] assign_cnt
);

    localparam logic [IW:0] LAST = (IW + 1)'(K - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW:0]   r_cnt;
    logic [CW-1:0] r_assign_cnt;
    logic          r_live;
    logic          w_accept;
    logic          w_consume;
    logic          w_last;

    // r_live keeps dist_ready low until the first clock after reset releases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= COLLECT;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dist_ready  = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            COLLECT: begin
                dist_ready = r_live;
                if (w_accept && w_last) w_state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (w_consume) w_state_nxt = COLLECT;
            end
            default: w_state_nxt = COLLECT;
        endcase
        if (clear) w_state_nxt = COLLECT;
    end

    assign w_accept  = dist_valid && dist_ready && !clear;
    assign w_consume = out_valid && out_ready && !clear;
    assign w_last    = (r_cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_assign_cnt <= '0;
        end else if (w_consume) begin
            r_assign_cnt <= r_assign_cnt + 1'b1;
        end
    end

    min_cmp_reg #(
        .DW(DW),
        .IW(IW)
    ) u_min (
        .clk        (clk),
        .reset      (reset),
        .i_en       (w_accept),
        .i_first    (r_cnt == '0),
        .i_dist     (dist_in),
        .i_idx      (r_cnt[IW-1:0]),
        .o_best_dist(best_dist),
        .o_best_idx (best_idx)
    );

    assign assign_cnt = r_assign_cnt;

endmodule

// File: tb/tb_nearest_centroid_sel.sv
// Directed self-checking bench for nearest_centroid_sel with K=4, DW=64, CW=16.
module tb_nearest_centroid_sel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [63:0] dist_in = '0;
    logic        dist_valid = 1'b0;
    logic        dist_ready;
    logic [1:0]  best_idx;
    logic [63:0] best_dist;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] assign_cnt;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [15:0] exp_cnt = '0;

    nearest_centroid_sel #(
        .DW(64),
        .K (4),
        .CW(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .dist_in   (dist_in),
        .dist_valid(dist_valid),
        .dist_ready(dist_ready),
        .best_idx  (best_idx),
        .best_dist (best_dist),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .assign_cnt(assign_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds dist_valid high until the beat is taken; leaves it high for back-to-back use.
    task automatic send_beat(input logic [63:0] d);
        int unsigned waited = 0;
        dist_in    = d;
        dist_valid = 1'b1;
        while (dist_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            n_total++;
            n_bad++;
            $display("FAIL beat_timeout: dist_ready=%b after %0d cycles, required 1", dist_ready, waited);
        end
        tick();
    endtask

    task automatic feed4(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
        send_beat(a);
        send_beat(b);
        send_beat(c);
        send_beat(d);
        dist_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_total++;
        if (assign_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_assign_cnt: got %0d want 0", assign_cnt); end
        n_total++;
        if (best_idx !== 2'd0 || best_dist !== 64'd0) begin
            n_bad++; $display("FAIL rst_best: got idx=%0d dist=%0d want 0/0", best_idx, best_dist);
        end
        n_total++;
        if (dist_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_early: got %b want 0", dist_ready); end
        tick();
        n_total++;
        if (dist_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", dist_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        feed4(64'd40, 64'd25, 64'd90, 64'd30);
        n_total++;
        if (out_valid !== 1'b1 || dist_ready !== 1'b0) begin
            n_bad++; $display("FAIL basic_hold: got valid=%b ready=%b want 1/0", out_valid, dist_ready);
        end
        n_total++;
        if (best_idx !== 2'd1 || best_dist !== 64'd25) begin
            n_bad++; $display("FAIL basic_result: got idx=%0d dist=%0d want 1/25", best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (out_valid !== 1'b0 || dist_ready !== 1'b1) begin
            n_bad++; $display("FAIL basic_ready_back: got valid=%b ready=%b want 0/1", out_valid, dist_ready);
        end
        n_total++;
        if (assign_cnt !== exp_cnt) begin n_bad++; $display("FAIL basic_cnt: got %0d want %0d", assign_cnt, exp_cnt); end
    endtask

    task automatic test_tie();
        feed4(64'd7, 64'd3, 64'd3, 64'd9);
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd1 || best_dist !== 64'd3) begin
            n_bad++; $display("FAIL tie_lower: got v=%b idx=%0d dist=%0d want 1/1/3", out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        feed4(64'd0, 64'd0, 64'd0, 64'd0);
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd0 || best_dist !== 64'd0) begin
            n_bad++; $display("FAIL tie_zero: got v=%b idx=%0d dist=%0d want 1/0/0", out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (assign_cnt !== exp_cnt) begin n_bad++; $display("FAIL tie_cnt: got %0d want %0d", assign_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        feed4(64'd5, 64'd4, 64'd3, 64'd2);
        dist_valid = 1'b1;
        dist_in    = 64'd1;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || dist_ready !== 1'b0 || best_idx !== 2'd3 || best_dist !== 64'd2) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b idx=%0d dist=%0d want 1/0/3/2",
                         i, out_valid, dist_ready, best_idx, best_dist);
            end
            tick();
        end
        dist_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (out_valid !== 1'b0 || assign_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL bp_consume: got v=%b cnt=%0d want 0/%0d", out_valid, assign_cnt, exp_cnt);
        end
        // a fresh point must need all four beats, proving none of the HOLD offers slipped in
        send_beat(64'd10);
        send_beat(64'd20);
        send_beat(64'd30);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_leak: got v=%b want 0", out_valid); end
        send_beat(64'd40);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd0 || best_dist !== 64'd10) begin
            n_bad++; $display("FAIL bp_next: got v=%b idx=%0d dist=%0d want 1/0/10", out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_width_bubbles();
        logic [63:0] v [4];
        v[0] = 64'h8000_0000_0000_0001;
        v[1] = 64'h8000_0000_0000_0000;
        v[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        v[3] = 64'h8000_0000_0000_0005;
        for (int i = 0; i < 4; i++) begin
            send_beat(v[i]);
            dist_valid = 1'b0;
            if (i < 3) begin
                tick();
                tick();
            end
            if (i == 1) begin
                n_total++;
                if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_partial: got v=%b want 0", out_valid); end
            end
        end
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd1 || best_dist !== 64'h8000_0000_0000_0000) begin
            n_bad++; $display("FAIL width_result: got v=%b idx=%0d dist=%h want 1/1/8000000000000000",
                              out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_clear();
        send_beat(64'd1);
        send_beat(64'd2);
        clear      = 1'b1;
        dist_in    = 64'd0;
        tick();
        clear      = 1'b0;
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || assign_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL clr_mid: got v=%b cnt=%0d want 0/%0d", out_valid, assign_cnt, exp_cnt);
        end
        send_beat(64'd8);
        send_beat(64'd6);
        send_beat(64'd9);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_restart_len: got v=%b want 0", out_valid); end
        send_beat(64'd1);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd3 || best_dist !== 64'd1) begin
            n_bad++; $display("FAIL clr_restart: got v=%b idx=%0d dist=%0d want 1/3/1", out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (assign_cnt !== exp_cnt) begin n_bad++; $display("FAIL clr_cnt: got %0d want %0d", assign_cnt, exp_cnt); end

        out_ready = 1'b0;
        feed4(64'd3, 64'd2, 64'd1, 64'd0);
        n_total++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_hold_pre: got v=%b want 1", out_valid); end
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || dist_ready !== 1'b1 || assign_cnt !== exp_cnt) begin
            n_bad++; $display("FAIL clr_hold: got v=%b rdy=%b cnt=%0d want 0/1/%0d",
                              out_valid, dist_ready, assign_cnt, exp_cnt);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        send_beat(64'd3);
        send_beat(64'd4);
        dist_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = '0;
        n_total++;
        if (out_valid !== 1'b0 || assign_cnt !== 16'd0 || dist_ready !== 1'b0) begin
            n_bad++; $display("FAIL arst_now: got v=%b cnt=%0d rdy=%b want 0/0/0", out_valid, assign_cnt, dist_ready);
        end
        #2;
        reset = 1'b0;
        tick();
        send_beat(64'd50);
        send_beat(64'd60);
        send_beat(64'd70);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_partial: got v=%b want 0", out_valid); end
        send_beat(64'd45);
        dist_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || best_idx !== 2'd3 || best_dist !== 64'd45) begin
            n_bad++; $display("FAIL arst_point: got v=%b idx=%0d dist=%0d want 1/3/45", out_valid, best_idx, best_dist);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        n_total++;
        if (assign_cnt !== exp_cnt) begin n_bad++; $display("FAIL arst_cnt: got %0d want %0d", assign_cnt, exp_cnt); end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_width_bubbles();
        test_clear();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
